counter_sched: RTL and testbench
================================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter BASE_DIV, 12_500_000, clock cycles per tick at Speed=01.
REQ-002 Parameter DIV_W, 28, divider width; SHALL hold 4*BASE_DIV-1.
REQ-003 Clock  input  1  sole clock; all state updates on posedge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  level; start/resume request, sampled each posedge.
REQ-006 Stop  input  1  level; pause/abort request, sampled each posedge.
REQ-007 Speed  input  2  tick rate select, captured at start.
REQ-008 Limit  input  8  terminal count, captured at start.
REQ-009 Enable  output  1  combinational count-enable tick to the 8-bit counter datapath.
REQ-010 CounterValue  output  8  current count.
REQ-011 Busy  output  1  high in RUN or PAUSE.
REQ-012 Done  output  1  one-cycle pulse on terminal count.

Function
REQ-013 FSM states SHALL be IDLE, RUN, PAUSE, DONE.
REQ-014 Tick period P SHALL be: Speed 00 -> 1, 01 -> BASE_DIV, 10 -> 2*BASE_DIV, 11 -> 4*BASE_DIV cycles.
REQ-015 IDLE or DONE with Start=1, Stop=0 -> RUN next cycle; same edge clears CounterValue to 0, captures Speed and Limit, loads divider with P-1.
REQ-016 In RUN the divider SHALL decrement each cycle; at 0, Enable=1 for that cycle and divider reloads P-1.
REQ-017 Enable SHALL be 0 in every state except RUN.
REQ-018 First Enable SHALL occur P cycles after entering RUN; subsequent Enables every P cycles.
REQ-019 CounterValue SHALL increment modulo 256 on each edge where Enable=1.
REQ-020 Terminal event: Enable=1 and CounterValue == captured Limit-1 (mod 256); Limit=0 means 256 ticks (255 -> 0).
REQ-021 On terminal event Done SHALL pulse high for exactly the following cycle.
REQ-022 RUN with Stop=1 -> PAUSE; divider and CounterValue hold; an Enable in the same cycle still counts.
REQ-023 PAUSE with Start=1, Stop=0 -> RUN, resuming divider from held value; PAUSE with Stop=1 -> IDLE, CounterValue cleared.
REQ-024 Start and Stop both high: Stop SHALL win in every state.
REQ-025 Start while in RUN SHALL be ignored; Speed/Limit changes after capture SHALL be ignored until next start.
REQ-026 DONE SHALL hold CounterValue until Start (restart) or Reset; Stop in DONE -> IDLE, CounterValue cleared.

Reset
REQ-027 Reset=1 at posedge SHALL force IDLE, CounterValue=0, divider=0, Done=0, Busy=0, Enable=0, captured Speed/Limit=0.
REQ-028 Reset SHALL override Start/Stop and take effect mid-RUN or mid-PAUSE in the same edge.

Configuration
REQ-029 Macro COUNTER_SCHED_WRAP_EN SHALL select terminal behaviour.
REQ-030 Defined: terminal event wraps CounterValue to 0, pulses Done, stays in RUN (free-running; divider continues unchanged).
REQ-031 Undefined: terminal event moves to DONE with CounterValue = Limit; DONE unreachable otherwise.

Structure
REQ-032 Shared package counter_sched_pkg SHALL hold the FSM state enum and the Speed encoding constants.
REQ-033 Divider SHALL be one sub-module rate_divider (load, run, hold, reload-on-zero, tick out); counter and FSM stay in counter_sched.

Verification (BASE_DIV=4, DIV_W=5)
REQ-034 Reset mid-RUN at CounterValue=5 -> next cycle IDLE, CounterValue=0, Busy=0, no Enable.
REQ-035 Speed=01, Limit=3, one-cycle Start -> Enable at RUN cycles 4,8,12; Done pulse after third; state DONE, CounterValue=3 (wrap off).
REQ-036 Speed=00, Limit=0, wrap off -> 256 consecutive Enables, then DONE with CounterValue=0, single Done pulse.
REQ-037 Speed=10, Stop for 10 cycles after 5 RUN cycles, then Start -> no Enable during PAUSE; next Enable 3 cycles after resume.
REQ-038 Start and Stop high together in IDLE -> stays IDLE; in RUN -> PAUSE.
REQ-039 COUNTER_SCHED_WRAP_EN defined, Speed=00, Limit=2 -> CounterValue 0,1,0,1...; Done every 2nd cycle; Busy stays 1.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types for the counter scheduler: FSM state encoding and tick-rate select codes.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] SPEED_CLK   = 2'b00;
    localparam logic [1:0] SPEED_BASE  = 2'b01;
    localparam logic [1:0] SPEED_BASE2 = 2'b10;
    localparam logic [1:0] SPEED_BASE4 = 2'b11;

endpackage

// File: rtl/counter_sched_rate_divider.sv
// Tick divider: loadable down-counter that reloads on zero and emits a tick while running.
module rate_divider #(
    parameter int DIV_W = 28
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             run,
    input  logic [DIV_W-1:0] reload_val,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (run) begin
            if (count_q == '0) count_q <= reload_val;
            else               count_q <= count_q - DIV_W'(1);
        end
    end

    assign tick = run && (count_q == '0);

endmodule

// File: rtl/counter_sched.sv
// Tick-paced 8-bit counter with start/pause/stop control and terminal-count Done pulse.
// Build option: COUNTER_SCHED_WRAP_EN makes the terminal count wrap to 0 and keep running.
//
// state    | meaning
// ST_IDLE  | stopped, count cleared, waiting for Start
// ST_RUN   | divider running, Enable ticks advance the count
// ST_PAUSE | divider and count frozen, Start resumes, Stop aborts
// ST_DONE  | terminal count reached, count held at Limit
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int BASE_DIV = 12_500_000,
    parameter int DIV_W    = 28
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] speed,
    input  logic [7:0] limit,
    output logic       enable,
    output logic [7:0] counter_value,
    output logic       busy,
    output logic       done
);

    state_t     state, state_next;
    logic [1:0] speed_q;
    logic [7:0] limit_q;
    logic [7:0] count_q;
    logic [7:0] count_inc;
    logic       done_q;
    logic       tick;
    logic       terminal;
    logic       launch;
    logic       clear;

    function automatic logic [DIV_W-1:0] period_m1(input logic [1:0] sel);
        case (sel)
            SPEED_CLK:   return '0;
            SPEED_BASE:  return DIV_W'(BASE_DIV - 1);
            SPEED_BASE2: return DIV_W'(2 * BASE_DIV - 1);
            default:     return DIV_W'(4 * BASE_DIV - 1);
        endcase
    endfunction

    rate_divider #(.DIV_W(DIV_W)) u_div (
        .clock      (clock),
        .reset      (reset),
        .load       (launch),
        .load_val   (period_m1(speed)),
        .run        (state == ST_RUN),
        .reload_val (period_m1(speed_q)),
        .tick       (tick)
    );

    // Limit 0 compares against 255, giving a full 256-tick run.
    assign terminal = tick && (count_q == (limit_q - 8'd1));

`ifdef COUNTER_SCHED_WRAP_EN
    assign count_inc = terminal ? 8'd0 : count_q + 8'd1;
`else
    assign count_inc = count_q + 8'd1;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next = ST_RUN;
                    launch     = 1'b1;
                end
            end
            ST_RUN: begin
`ifdef COUNTER_SCHED_WRAP_EN
                if (stop) state_next = ST_PAUSE;
`else
                // Completion takes priority so a run never pauses holding count == Limit.
                if (terminal)  state_next = ST_DONE;
                else if (stop) state_next = ST_PAUSE;
`endif
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    clear      = 1'b1;
                end else if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    clear      = 1'b1;
                end else if (start) begin
                    state_next = ST_RUN;
                    launch     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            speed_q <= '0;
            limit_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= terminal;
            if (launch) begin
                count_q <= '0;
                speed_q <= speed;
                limit_q <= limit;
            end else if (clear) begin
                count_q <= '0;
            end else if (tick) begin
                count_q <= count_inc;
            end
        end
    end

    assign enable        = tick;
    assign counter_value = count_q;
    assign busy          = (state == ST_RUN) || (state == ST_PAUSE);
    assign done          = done_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with BASE_DIV=4 (tick periods 1/4/8/16 cycles).
module tb_counter_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [1:0] speed;
    logic [7:0] limit;
    logic       enable;
    logic [7:0] counter_value;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int en_cnt;
    int dn_cnt;

    counter_sched #(.BASE_DIV(4), .DIV_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .speed         (speed),
        .limit         (limit),
        .enable        (enable),
        .counter_value (counter_value),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; speed = 2'b00; limit = 8'd0;
        step();
        step();
        check_val("rst_count", counter_value, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_enable", enable, 0);
        check_val("rst_done", done, 0);
        reset = 1'b0;

`ifndef COUNTER_SCHED_WRAP_EN
        // Speed 01, Limit 3; later Speed/Limit changes and a Start in RUN are ignored
        speed = 2'b01; limit = 8'd3; start = 1'b1;
        step();
        start = 1'b0; speed = 2'b00; limit = 8'd1;
        check_val("a_busy", busy, 1);
        for (int c = 1; c <= 12; c++) begin
            check_val($sformatf("a_en_c%0d", c), enable, (c % 4 == 0) ? 1 : 0);
            start = (c == 6) ? 1'b1 : 1'b0;
            step();
        end
        start = 1'b0;
        check_val("a_done_pulse", done, 1);
        check_val("a_done_busy", busy, 0);
        check_val("a_done_count", counter_value, 3);
        step();
        check_val("a_done_low", done, 0);
        check_val("a_hold_count", counter_value, 3);
        check_val("a_done_no_en", enable, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_val("a_stop_clear", counter_value, 0);
        check_val("a_stop_idle", busy, 0);

        // Speed 00, Limit 0: 256 ticks then DONE at 0 with one Done pulse
        speed = 2'b00; limit = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        en_cnt = 0; dn_cnt = 0;
        for (int i = 1; i <= 256; i++) begin
            en_cnt += int'(enable);
            dn_cnt += int'(done);
            step();
        end
        check_val("b_done_pulse", done, 1);
        check_val("b_count", counter_value, 0);
        check_val("b_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            dn_cnt += int'(done);
            step();
        end
        check_val("b_enables", en_cnt, 256);
        check_val("b_done_pulses", dn_cnt, 1);

        // Restart from DONE, then Stop in a ticking RUN cycle still counts
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("b_restart_busy", busy, 1);
        check_val("b_restart_count", counter_value, 0);
        stop = 1'b1;
        step();
        check_val("b_pause_busy", busy, 1);
        check_val("b_pause_count", counter_value, 1);
        check_val("b_pause_no_en", enable, 0);
        step();
        stop = 1'b0;
        check_val("b_abort_count", counter_value, 0);
        check_val("b_abort_busy", busy, 0);
`else
        // Wrap build: Speed 00, Limit 2 free-runs 0,1,0,1 with Done every 2nd cycle
        speed = 2'b00; limit = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_val($sformatf("w_count_c%0d", c), counter_value, (c - 1) % 2);
            check_val($sformatf("w_done_c%0d", c), done, (c >= 3 && (c % 2) == 1) ? 1 : 0);
            check_val($sformatf("w_busy_c%0d", c), busy, 1);
            step();
        end
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        check_val("w_abort_busy", busy, 0);
`endif

        // Start and Stop together: IDLE stays, RUN pauses
        start = 1'b1; stop = 1'b1;
        step();
        check_val("c_idle_both", busy, 0);
        stop = 1'b0; speed = 2'b01; limit = 8'd10;
        step();
        check_val("c_run", busy, 1);
        stop = 1'b1;
        step();
        check_val("c_pause_busy", busy, 1);
        check_val("c_pause_no_en", enable, 0);
        start = 1'b0;
        step();
        stop = 1'b0;
        check_val("c_abort", busy, 0);

        // Speed 10 (P=8): Stop in RUN cycle 5, 10 paused cycles, resume
        speed = 2'b10; limit = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            en_cnt += int'(enable);
            step();
        end
        stop = 1'b1;
        en_cnt += int'(enable);
        step();
        stop = 1'b0;
        check_val("d_pre_enables", en_cnt, 0);
        check_val("d_paused", busy, 1);
        for (int i = 0; i < 10; i++) begin
            en_cnt += int'(enable);
            step();
        end
        check_val("d_pause_enables", en_cnt, 0);
        check_val("d_pause_busy", busy, 1);
        check_val("d_pause_count", counter_value, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("d_resume_r1", enable, 0);
        step();
        check_val("d_resume_r2", enable, 0);
        step();
        check_val("d_resume_r3", enable, 1);
        step();
        check_val("d_resume_count", counter_value, 1);
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        check_val("d_abort", busy, 0);

        // Reset mid-RUN at count 5
        speed = 2'b00; limit = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_val("e_count5", counter_value, 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("e_rst_count", counter_value, 0);
        check_val("e_rst_busy", busy, 0);
        check_val("e_rst_enable", enable, 0);
        check_val("e_rst_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
